// File: rtl/aes_job_sequencer_if.sv
// rtl/aes_job_sequencer_if.sv - source/sink request and engine control bundle for aes_job_sequencer
interface aes_job_sequencer_if;
  logic        src_req_o;
  logic [31:0] src_addr_o;
  logic [15:0] src_len_o;
  logic        src_ready_i;
  logic        sink_req_o;
  logic [31:0] sink_addr_o;
  logic [15:0] sink_len_o;
  logic        sink_ready_i;
  logic        sink_done_i;
  logic        eng_clear_o;
  logic        eng_enable_o;
  logic        eng_start_o;
  logic        eng_valid_i;

  modport master (
    output src_req_o, src_addr_o, src_len_o,
    input  src_ready_i,
    output sink_req_o, sink_addr_o, sink_len_o,
    input  sink_ready_i, sink_done_i,
    output eng_clear_o, eng_enable_o, eng_start_o,
    input  eng_valid_i
  );

  modport slave (
    input  src_req_o, src_addr_o, src_len_o,
    output src_ready_i,
    input  sink_req_o, sink_addr_o, sink_len_o,
    output sink_ready_i, sink_done_i,
    input  eng_clear_o, eng_enable_o, eng_start_o,
    output eng_valid_i
  );
endinterface

// File: rtl/aes_job_sequencer.sv
// rtl/aes_job_sequencer.sv - block-by-block job sequencer driving plaintext fetch, ciphertext store and the AES engine
module aes_job_sequencer #(
  parameter int BLOCK_WORDS = 8,
  parameter int NB_W        = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                start_i,
  input  logic [31:0]         pt_addr_i,
  input  logic [31:0]         ct_addr_i,
  input  logic [NB_W-1:0]     num_blocks_i,
  aes_job_sequencer_if.master bus,
  output logic                busy_o,
  output logic                done_o,
  output logic [NB_W-1:0]     blocks_done_o
);
  localparam logic [31:0] ADDR_STEP = 32'(4 * BLOCK_WORDS);
  localparam logic [15:0] BLOCK_LEN = 16'(BLOCK_WORDS);

  typedef enum logic [2:0] {IDLE, STARTING, REQUEST_DATA, WORKING, FINISHED} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pt_q, pt_d, ct_q, ct_d;
  logic [NB_W-1:0] nb_q, nb_d, cnt_q, cnt_d;
  logic            src_acc_q, src_acc_d, sink_acc_q, sink_acc_d;
  logic            valid_seen_q, valid_seen_d, sdone_seen_q, sdone_seen_d;
  logic            first_q, first_d;

  logic            src_req, sink_req, src_ok, sink_ok, valid_ok, sdone_ok;
  logic [NB_W-1:0] cnt_inc;

  assign src_req  = (state_q == REQUEST_DATA) && !src_acc_q && !clear_i;
  assign sink_req = (state_q == REQUEST_DATA) && !sink_acc_q && !clear_i;
  // A side counts as accepted once its ready was sampled while its request was up.
  assign src_ok   = src_acc_q | (src_req & bus.src_ready_i);
  assign sink_ok  = sink_acc_q | (sink_req & bus.sink_ready_i);
  assign valid_ok = valid_seen_q | bus.eng_valid_i;
  assign sdone_ok = sdone_seen_q | bus.sink_done_i;
  assign cnt_inc  = cnt_q + NB_W'(1);

  always_comb begin
    state_d      = state_q;
    pt_d         = pt_q;
    ct_d         = ct_q;
    nb_d         = nb_q;
    cnt_d        = cnt_q;
    src_acc_d    = src_acc_q;
    sink_acc_d   = sink_acc_q;
    valid_seen_d = valid_seen_q;
    sdone_seen_d = sdone_seen_q;
    first_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          cnt_d = '0;
          if (num_blocks_i == '0) begin
            state_d = FINISHED;
          end else begin
            pt_d    = pt_addr_i;
            ct_d    = ct_addr_i;
            nb_d    = num_blocks_i;
            state_d = STARTING;
          end
        end
      end
      STARTING: state_d = REQUEST_DATA;
      REQUEST_DATA: begin
        src_acc_d  = src_ok;
        sink_acc_d = sink_ok;
        if (src_ok && sink_ok) begin
          src_acc_d  = 1'b0;
          sink_acc_d = 1'b0;
          first_d    = 1'b1;
          state_d    = WORKING;
        end
      end
      WORKING: begin
        valid_seen_d = valid_ok;
        sdone_seen_d = sdone_ok;
        if (valid_ok && sdone_ok) begin
          valid_seen_d = 1'b0;
          sdone_seen_d = 1'b0;
          cnt_d        = cnt_inc;
          pt_d         = pt_q + ADDR_STEP;
          ct_d         = ct_q + ADDR_STEP;
          state_d      = (cnt_inc == nb_q) ? FINISHED : REQUEST_DATA;
        end
      end
      FINISHED: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d      = IDLE;
      cnt_d        = '0;
      src_acc_d    = 1'b0;
      sink_acc_d   = 1'b0;
      valid_seen_d = 1'b0;
      sdone_seen_d = 1'b0;
      first_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      pt_q         <= '0;
      ct_q         <= '0;
      nb_q         <= '0;
      cnt_q        <= '0;
      src_acc_q    <= 1'b0;
      sink_acc_q   <= 1'b0;
      valid_seen_q <= 1'b0;
      sdone_seen_q <= 1'b0;
      first_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pt_q         <= pt_d;
      ct_q         <= ct_d;
      nb_q         <= nb_d;
      cnt_q        <= cnt_d;
      src_acc_q    <= src_acc_d;
      sink_acc_q   <= sink_acc_d;
      valid_seen_q <= valid_seen_d;
      sdone_seen_q <= sdone_seen_d;
      first_q      <= first_d;
    end
  end

  assign busy_o           = (state_q != IDLE);
  assign done_o           = (state_q == FINISHED) && !clear_i;
  assign blocks_done_o    = cnt_q;
  assign bus.src_req_o    = src_req;
  assign bus.sink_req_o   = sink_req;
  assign bus.src_addr_o   = pt_q;
  assign bus.sink_addr_o  = ct_q;
  assign bus.src_len_o    = busy_o ? BLOCK_LEN : '0;
  assign bus.sink_len_o   = busy_o ? BLOCK_LEN : '0;
  assign bus.eng_enable_o = busy_o;
  assign bus.eng_start_o  = (state_q == WORKING) && first_q && !clear_i;
  // Soft clear reaches the engine combinationally but stays quiet while in reset.
  assign bus.eng_clear_o  = rst_ni && (clear_i || (state_q == STARTING));
endmodule

// File: tb/tb_aes_job_sequencer.sv
// tb/tb_aes_job_sequencer.sv - job table plus address scoreboard for aes_job_sequencer
module tb_aes_job_sequencer;
  logic        clk = 1'b0;
  logic        rst_n, clear, start;
  logic [31:0] pt_addr, ct_addr;
  logic [15:0] num_blocks;
  logic        busy, done;
  logic [15:0] blocks_done;

  always #5 clk = ~clk;

  aes_job_sequencer_if bus();

  aes_job_sequencer #(.BLOCK_WORDS(8), .NB_W(16)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clear_i      (clear),
    .start_i      (start),
    .pt_addr_i    (pt_addr),
    .ct_addr_i    (ct_addr),
    .num_blocks_i (num_blocks),
    .bus          (bus),
    .busy_o       (busy),
    .done_o       (done),
    .blocks_done_o(blocks_done)
  );

  typedef struct {
    int          nb;
    logic [31:0] pt;
    logic [31:0] ct;
    int          src_dly;
    int          sink_dly;
    int          vdly;
    int          ddly;
    bit          poke;
    int          clr_blk;
    logic [31:0] exp_src;
    logic [31:0] exp_sink;
    int          exp_starts;
    int          exp_done;
    int          exp_blocks;
  } job_t;

  job_t        jobs[8];
  int          total = 0, bad = 0;
  int          n_start = 0, n_done = 0, n_req = 0;
  logic [31:0] src_q[$], sink_q[$];
  logic [31:0] last_src = '0, last_sink = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (bus.eng_start_o) n_start++;
    if (done) n_done++;
    if (bus.src_req_o || bus.sink_req_o) n_req++;
  endtask

  task automatic run_job(input job_t j);
    int s0, d0, r0, guard, sc, kc, tend, d1;
    bit sa, ka, cleared;
    s0 = n_start; d0 = n_done; r0 = n_req; cleared = 1'b0;
    src_q.delete();
    sink_q.delete();
    for (int i = 0; i < j.nb; i++) begin
      src_q.push_back(j.pt + 32'(32 * i));
      sink_q.push_back(j.ct + 32'(32 * i));
    end
    pt_addr = j.pt; ct_addr = j.ct; num_blocks = 16'(j.nb); start = 1'b1;
    step();
    start = 1'b0; pt_addr = $urandom; ct_addr = $urandom; num_blocks = 16'($urandom_range(1, 9));
    if (j.nb == 0) begin
      d1 = int'(done);
      step();
      d1 += int'(done);
      chk("zero_done_once", d1, 1);
      chk("zero_no_req", n_req - r0, 0);
      step();
      chk("zero_idle", busy, 0);
    end else begin
      chk("starting_clear", bus.eng_clear_o, 1);
      chk("starting_busy", busy, 1);
      step();
      chk("req_latency", {bus.src_req_o, bus.sink_req_o}, 2'b11);
      for (int b = 0; b < j.nb && !cleared; b++) begin
        sa = 1'b0; ka = 1'b0; sc = 0; kc = 0; guard = 0;
        while (!(sa && ka) && guard < 200) begin
          if (!sa) begin
            chk("src_req_held", bus.src_req_o, 1);
            chk("src_addr", bus.src_addr_o, src_q[0]);
            bus.src_ready_i = (sc >= j.src_dly);
            if (bus.src_ready_i) begin
              chk("src_len", bus.src_len_o, 8);
              last_src = src_q.pop_front();
              sa = 1'b1;
            end
            sc++;
          end else begin
            chk("src_req_dropped", bus.src_req_o, 0);
            bus.src_ready_i = 1'b0;
          end
          if (!ka) begin
            chk("sink_req_held", bus.sink_req_o, 1);
            chk("sink_addr", bus.sink_addr_o, sink_q[0]);
            bus.sink_ready_i = (kc >= j.sink_dly);
            if (bus.sink_ready_i) begin
              chk("sink_len", bus.sink_len_o, 8);
              last_sink = sink_q.pop_front();
              ka = 1'b1;
            end
            kc++;
          end else begin
            chk("sink_req_dropped", bus.sink_req_o, 0);
            bus.sink_ready_i = 1'b0;
          end
          step();
          guard++;
        end
        bus.src_ready_i = 1'b0; bus.sink_ready_i = 1'b0;
        chk("handshake_done", sa && ka, 1);
        chk("eng_start", bus.eng_start_o, 1);
        if (b == j.clr_blk) begin
          clear = 1'b1;
          #1;
          chk("clear_eng_clear", bus.eng_clear_o, 1);
          chk("clear_no_done", done, 0);
          step();
          clear = 1'b0;
          chk("clear_idle", busy, 0);
          chk("clear_blocks", blocks_done, 0);
          chk("clear_no_req", bus.src_req_o | bus.sink_req_o, 0);
          cleared = 1'b1;
        end else begin
          tend = (j.vdly > j.ddly) ? j.vdly : j.ddly;
          for (int t = 0; t <= tend; t++) begin
            bus.eng_valid_i = (t == j.vdly);
            bus.sink_done_i = (t == j.ddly);
            start = j.poke && (t == 0);
            if (start) begin
              pt_addr = $urandom; num_blocks = 16'($urandom_range(1, 9));
            end
            step();
          end
          bus.eng_valid_i = 1'b0; bus.sink_done_i = 1'b0; start = 1'b0;
          if (b == j.nb - 1) begin
            chk("done_pulse", done, 1);
            chk("blocks_final", blocks_done, j.exp_blocks);
            step();
            chk("done_once", done, 0);
            chk("idle_after", busy, 0);
          end else begin
            chk("blocks_mid", blocks_done, b + 1);
          end
        end
      end
      chk("last_src_addr", last_src, j.exp_src);
      chk("last_sink_addr", last_sink, j.exp_sink);
    end
    chk("start_pulses", n_start - s0, j.exp_starts);
    chk("done_pulses", n_done - d0, j.exp_done);
  endtask

  initial begin
    int s0, d0, r0;
    jobs[0] = '{1, 32'h1000, 32'h2000, 0, 0, 0, 0, 1'b0, -1, 32'h1000, 32'h2000, 1, 1, 1};
    jobs[1] = '{3, 32'h1000, 32'h2000, 0, 0, 0, 0, 1'b0, -1, 32'h1040, 32'h2040, 3, 1, 3};
    jobs[2] = '{1, 32'h3000, 32'h4000, 5, 0, 1, 1, 1'b0, -1, 32'h3000, 32'h4000, 1, 1, 1};
    jobs[3] = '{2, 32'hFFFF_FFF0, 32'h8000, 0, 0, 2, 0, 1'b0, -1, 32'h0000_0010, 32'h8020, 2, 1, 2};
    jobs[4] = '{0, 32'h9000, 32'h9100, 0, 0, 0, 0, 1'b0, -1, 32'h0, 32'h0, 0, 1, 0};
    jobs[5] = '{2, 32'h5000, 32'h6000, 2, 3, 1, 1, 1'b1, -1, 32'h5020, 32'h6020, 2, 1, 2};
    jobs[6] = '{4, 32'h1000, 32'h2000, 0, 0, 0, 1, 1'b0, 1, 32'h1020, 32'h2020, 2, 0, 0};
    jobs[7] = '{2, 32'hA000, 32'hB000, 1, 1, 0, 3, 1'b0, -1, 32'hA020, 32'hB020, 2, 1, 2};

    rst_n = 1'b0; clear = 1'b0; start = 1'b0;
    pt_addr = '0; ct_addr = '0; num_blocks = '0;
    bus.src_ready_i = 1'b0; bus.sink_ready_i = 1'b0;
    bus.sink_done_i = 1'b0; bus.eng_valid_i = 1'b0;
    repeat (2) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_reqs", {bus.src_req_o, bus.sink_req_o}, 0);
    chk("rst_eng", {bus.eng_clear_o, bus.eng_enable_o, bus.eng_start_o}, 0);
    chk("rst_addrs", bus.src_addr_o | bus.sink_addr_o, 0);
    chk("rst_lens", {bus.src_len_o, bus.sink_len_o}, 0);
    chk("rst_blocks", blocks_done, 0);
    rst_n = 1'b1;
    step();

    for (int k = 0; k < 8; k++) begin
      run_job(jobs[k]);
      step();
    end

    // Reset dropped while requests are outstanding, then released.
    pt_addr = 32'h7000; ct_addr = 32'h7800; num_blocks = 16'd2; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("rst_mid_req", bus.src_req_o, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_async_req", {bus.src_req_o, bus.sink_req_o}, 0);
    chk("rst_mid_async_addr", bus.src_addr_o, 0);
    chk("rst_mid_async_busy", busy, 0);
    step();
    rst_n = 1'b1;
    s0 = n_start; d0 = n_done; r0 = n_req;
    repeat (4) step();
    chk("rst_resume_quiet", (n_start - s0) + (n_done - d0) + (n_req - r0), 0);
    chk("rst_resume_idle", busy, 0);
    run_job(jobs[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
